// File: rtl/soc_tcdm2axi_bridge_pkg.sv
// Shared types and AXI encodings for the SoC TCDM-to-AXI bridge.
package pkg_soc_interconnect;

  typedef enum logic {TXN_READ = 1'b0, TXN_WRITE = 1'b1} txn_type_e;

  localparam logic [2:0] AXI_SIZE_32B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        opc;
  } tcdm_rsp_t;

  // SLVERR and DECERR both map to a TCDM error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != AXI_RESP_OKAY) && (resp != AXI_RESP_EXOKAY);
  endfunction

endpackage

// File: rtl/soc_tcdm2axi_order_fifo.sv
// In-order record of issued transaction types; the head selects which AXI
// response channel may be accepted next.
module soc_tcdm2axi_order_fifo
  import pkg_soc_interconnect::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  txn_type_e push_type_i,
  input  logic      pop_i,
  output txn_type_e head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  txn_type_e      mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, rd_ptr_q;

  // Extra pointer bit distinguishes full from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o)  wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_i  && !empty_o) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= push_type_i;
  end

endmodule

// File: rtl/soc_tcdm2axi_bridge.sv
// TCDM slave to single-beat AXI4 master, responses returned in request order.
// Define SOC_TCDM2AXI_ERR_EN to report SLVERR/DECERR on tcdm_r_opc_o.
module soc_tcdm2axi_bridge
  import pkg_soc_interconnect::*;
#(
  parameter int unsigned AXI_ID_WIDTH   = 1,
  parameter int unsigned AXI_ID         = 0,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned MAX_TXNS       = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      tcdm_req_i,
  input  logic [31:0]               tcdm_add_i,
  input  logic                      tcdm_wen_i,
  input  logic [31:0]               tcdm_wdata_i,
  input  logic [3:0]                tcdm_be_i,
  output logic                      tcdm_gnt_o,
  output logic                      tcdm_r_valid_o,
  output logic [31:0]               tcdm_r_rdata_o,
  output logic                      tcdm_r_opc_o,
  output logic                      aw_valid_o,
  input  logic                      aw_ready_i,
  output logic [31:0]               aw_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   aw_id_o,
  output logic [2:0]                aw_prot_o,
  output logic [2:0]                aw_size_o,
  output logic [7:0]                aw_len_o,
  output logic [1:0]                aw_burst_o,
  output logic [AXI_USER_WIDTH-1:0] aw_user_o,
  output logic                      w_valid_o,
  input  logic                      w_ready_i,
  output logic [31:0]               w_data_o,
  output logic [3:0]                w_strb_o,
  output logic                      w_last_o,
  input  logic                      b_valid_i,
  output logic                      b_ready_o,
  input  logic [1:0]                b_resp_i,
  output logic                      ar_valid_o,
  input  logic                      ar_ready_i,
  output logic [31:0]               ar_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   ar_id_o,
  output logic [2:0]                ar_size_o,
  output logic [7:0]                ar_len_o,
  input  logic                      r_valid_i,
  output logic                      r_ready_o,
  input  logic [31:0]               r_data_i,
  input  logic [1:0]                r_resp_i,
  input  logic                      r_last_i
);

  logic      fifo_full, fifo_empty;
  txn_type_e head_type;
  logic      aw_done_q, w_done_q;
  logic      rd_req, wr_req, wr_gnt;
  logic      ar_hs, aw_hs, w_hs, r_hs, b_hs;
  tcdm_rsp_t rsp_d, rsp_q;

  // The TCDM master holds its request until gnt, so valids and payloads stay
  // stable while the slave stalls; a full FIFO cannot reappear during a wait.
  assign rd_req = !rst_i && tcdm_req_i &&  tcdm_wen_i && !fifo_full;
  assign wr_req = !rst_i && tcdm_req_i && !tcdm_wen_i && !fifo_full;

  assign ar_valid_o = rd_req;
  assign aw_valid_o = wr_req && !aw_done_q;
  assign w_valid_o  = wr_req && !w_done_q;

  assign ar_hs = ar_valid_o && ar_ready_i;
  assign aw_hs = aw_valid_o && aw_ready_i;
  assign w_hs  = w_valid_o  && w_ready_i;

  assign wr_gnt     = wr_req && (aw_done_q || aw_hs) && (w_done_q || w_hs);
  assign tcdm_gnt_o = ar_hs || wr_gnt;

  assign aw_addr_o  = tcdm_add_i;
  assign aw_id_o    = AXI_ID_WIDTH'(AXI_ID);
  assign aw_prot_o  = 3'b000;
  assign aw_size_o  = AXI_SIZE_32B;
  assign aw_len_o   = 8'd0;
  assign aw_burst_o = AXI_BURST_INCR;
  assign aw_user_o  = '0;
  assign w_data_o   = tcdm_wdata_i;
  assign w_strb_o   = tcdm_be_i;
  assign w_last_o   = 1'b1;
  assign ar_addr_o  = tcdm_add_i;
  assign ar_id_o    = AXI_ID_WIDTH'(AXI_ID);
  assign ar_size_o  = AXI_SIZE_32B;
  assign ar_len_o   = 8'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i || wr_gnt) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_done_q <= aw_done_q || aw_hs;
      w_done_q  <= w_done_q  || w_hs;
    end
  end

  // Only the channel matching the oldest outstanding transaction is accepted.
  assign r_ready_o = !rst_i && !fifo_empty && (head_type == TXN_READ);
  assign b_ready_o = !rst_i && !fifo_empty && (head_type == TXN_WRITE);
  assign r_hs      = r_valid_i && r_ready_o;
  assign b_hs      = b_valid_i && b_ready_o;

  soc_tcdm2axi_order_fifo #(
    .DEPTH (MAX_TXNS)
  ) i_order_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (tcdm_gnt_o),
    .push_type_i (tcdm_wen_i ? TXN_READ : TXN_WRITE),
    .pop_i       (r_hs || b_hs),
    .head_o      (head_type),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    rsp_d       = '0;
    rsp_d.valid = r_hs || b_hs;
    if (r_hs) rsp_d.rdata = r_data_i;
`ifdef SOC_TCDM2AXI_ERR_EN
    rsp_d.opc = (r_hs && resp_is_err(r_resp_i)) || (b_hs && resp_is_err(b_resp_i));
`endif
  end

`ifdef SOC_TCDM2AXI_ERR_EN
  logic unused_in;
  assign unused_in = r_last_i;
`else
  logic unused_in;
  assign unused_in = ^{r_last_i, r_resp_i, b_resp_i};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) rsp_q <= '0;
    else       rsp_q <= rsp_d;
  end

  assign tcdm_r_valid_o = rsp_q.valid;
  assign tcdm_r_rdata_o = rsp_q.rdata;
  assign tcdm_r_opc_o   = rsp_q.opc;

endmodule

// File: tb/tb_soc_tcdm2axi_bridge.sv
// Directed scenarios followed by a randomized run against a transaction-level
// model of the bridge (in-order responses, word memory, outstanding cap).
module tb_soc_tcdm2axi_bridge;

  localparam int MAX_TXNS = 4;
`ifdef SOC_TCDM2AXI_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        tcdm_req_i, tcdm_wen_i;
  logic [31:0] tcdm_add_i, tcdm_wdata_i;
  logic [3:0]  tcdm_be_i;
  logic        tcdm_gnt_o, tcdm_r_valid_o, tcdm_r_opc_o;
  logic [31:0] tcdm_r_rdata_o;
  logic        aw_valid_o, aw_ready_i;
  logic [31:0] aw_addr_o;
  logic [0:0]  aw_id_o, ar_id_o;
  logic [2:0]  aw_prot_o, aw_size_o, ar_size_o;
  logic [7:0]  aw_len_o, ar_len_o;
  logic [1:0]  aw_burst_o;
  logic [5:0]  aw_user_o;
  logic        w_valid_o, w_ready_i, w_last_o;
  logic [31:0] w_data_o;
  logic [3:0]  w_strb_o;
  logic        b_valid_i, b_ready_o;
  logic [1:0]  b_resp_i;
  logic        ar_valid_o, ar_ready_i;
  logic [31:0] ar_addr_o;
  logic        r_valid_i, r_ready_o, r_last_i;
  logic [31:0] r_data_i;
  logic [1:0]  r_resp_i;

  soc_tcdm2axi_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tcdm_req_i(tcdm_req_i), .tcdm_add_i(tcdm_add_i), .tcdm_wen_i(tcdm_wen_i),
    .tcdm_wdata_i(tcdm_wdata_i), .tcdm_be_i(tcdm_be_i), .tcdm_gnt_o(tcdm_gnt_o),
    .tcdm_r_valid_o(tcdm_r_valid_o), .tcdm_r_rdata_o(tcdm_r_rdata_o), .tcdm_r_opc_o(tcdm_r_opc_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_id_o(aw_id_o),
    .aw_prot_o(aw_prot_o), .aw_size_o(aw_size_o), .aw_len_o(aw_len_o), .aw_burst_o(aw_burst_o),
    .aw_user_o(aw_user_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
    .w_last_o(w_last_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_id_o(ar_id_o),
    .ar_size_o(ar_size_o), .ar_len_o(ar_len_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
    .r_last_i(r_last_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    tcdm_req_i = 0; tcdm_wen_i = 0; tcdm_add_i = 0; tcdm_wdata_i = 0; tcdm_be_i = 0;
    aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
    b_valid_i = 0; b_resp_i = 0; r_valid_i = 0; r_data_i = 0; r_resp_i = 0; r_last_i = 1;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_gnt"},     tcdm_gnt_o,     0);
    chk({p, "_ar_valid"}, ar_valid_o,    0);
    chk({p, "_aw_valid"}, aw_valid_o,    0);
    chk({p, "_w_valid"},  w_valid_o,     0);
    chk({p, "_r_ready"},  r_ready_o,     0);
    chk({p, "_b_ready"},  b_ready_o,     0);
    chk({p, "_r_valid"},  tcdm_r_valid_o, 0);
    chk({p, "_rdata"},    tcdm_r_rdata_o, 0);
    chk({p, "_opc"},      tcdm_r_opc_o,  0);
  endtask

  // Reference helpers: initial memory contents, error words, byte-enable merge.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction
  function automatic bit err_word(input logic [31:0] a);
    return a[5:2] == 4'd7;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) old[b*8 +: 8] = nw[b*8 +: 8];
    return old;
  endfunction

  typedef struct { logic [31:0] data; logic opc; } exp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } beat_t;

  exp_t        exp_q[$];
  bit          ord_q[$];          // 1 = read, in grant order, until R/B handshake
  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];
  beat_t       r_q[$];
  beat_t       b_q[$];
  logic [31:0] ref_mem[int];
  logic [31:0] smem[int];

  bit          m_busy, m_wen, drain;
  logic [31:0] m_add, m_wdata;
  logic [3:0]  m_be;
  bit          ar_hs, aw_hs, w_hs, r_hs, b_hs;
  bit          p_ar_wait, p_aw_wait, p_w_wait;
  logic [31:0] p_ar_addr, p_aw_addr, c_ar_addr, c_aw_addr;
  logic [35:0] p_w, c_w;
  exp_t        e;
  beat_t       bt;
  logic [31:0] wa, old;
  logic [35:0] wd;

  initial begin
    idle();
    rst_i = 1;
    tick(); tick();
    settle();
    chk_zero("rst");
    rst_i = 0;
    settle();
    chk_zero("rst_rel");

    // Single read, R three cycles later.
    tcdm_req_i = 1; tcdm_wen_i = 1; tcdm_add_i = 32'h1A10_0004; ar_ready_i = 1;
    settle();
    chk("t1_ar_valid", ar_valid_o, 1);
    chk("t1_gnt", tcdm_gnt_o, 1);
    chk("t1_ar_addr", ar_addr_o, 32'h1A10_0004);
    chk("t1_ar_size", ar_size_o, 3'b010);
    chk("t1_ar_len", ar_len_o, 0);
    chk("t1_ar_id", ar_id_o, 0);
    tick();
    tcdm_req_i = 0; ar_ready_i = 0;
    repeat (2) begin
      settle();
      chk("t1_r_ready_wait", r_ready_o, 1);
      chk("t1_no_rvalid", tcdm_r_valid_o, 0);
      tick();
    end
    r_valid_i = 1; r_data_i = 32'hDEAD_BEEF; r_resp_i = 0;
    settle();
    chk("t1_r_ready", r_ready_o, 1);
    tick();
    r_valid_i = 0;
    settle();
    chk("t1_rvalid", tcdm_r_valid_o, 1);
    chk("t1_rdata", tcdm_r_rdata_o, 32'hDEAD_BEEF);
    chk("t1_opc", tcdm_r_opc_o, 0);
    tick();
    settle();
    chk("t1_rvalid_pulse", tcdm_r_valid_o, 0);

    // Write: W accepted two cycles before AW.
    tcdm_req_i = 1; tcdm_wen_i = 0; tcdm_add_i = 32'h1A10_0010;
    tcdm_wdata_i = 32'h1234_5678; tcdm_be_i = 4'b0101; w_ready_i = 1; aw_ready_i = 0;
    settle();
    chk("t2_aw_valid", aw_valid_o, 1);
    chk("t2_w_valid", w_valid_o, 1);
    chk("t2_w_strb", w_strb_o, 4'b0101);
    chk("t2_w_data", w_data_o, 32'h1234_5678);
    chk("t2_w_last", w_last_o, 1);
    chk("t2_gnt_w_only", tcdm_gnt_o, 0);
    tick();
    w_ready_i = 0;
    settle();
    chk("t2_w_done_drop", w_valid_o, 0);
    chk("t2_aw_hold", aw_valid_o, 1);
    chk("t2_gnt_wait", tcdm_gnt_o, 0);
    tick();
    aw_ready_i = 1;
    settle();
    chk("t2_gnt_aw", tcdm_gnt_o, 1);
    chk("t2_aw_addr", aw_addr_o, 32'h1A10_0010);
    chk("t2_aw_fixed", {aw_prot_o, aw_size_o, aw_len_o, aw_burst_o, aw_user_o, aw_id_o},
        {3'b000, 3'b010, 8'd0, 2'b01, 6'd0, 1'b0});
    tick();
    tcdm_req_i = 0; aw_ready_i = 0;
    settle();
    chk("t2_aw_clear", aw_valid_o, 0);
    chk("t2_b_ready", b_ready_o, 1);
    chk("t2_r_ready", r_ready_o, 0);
    b_valid_i = 1; b_resp_i = 0;
    tick();
    b_valid_i = 0;
    settle();
    chk("t2_rvalid", tcdm_r_valid_o, 1);
    chk("t2_rdata", tcdm_r_rdata_o, 0);
    tick();

    // Four outstanding reads fill the order FIFO.
    ar_ready_i = 1; tcdm_req_i = 1; tcdm_wen_i = 1;
    for (int i = 0; i < 4; i++) begin
      tcdm_add_i = 32'h1000_0000 + 32'(i * 4);
      settle();
      chk("t3_gnt", tcdm_gnt_o, 1);
      tick();
    end
    tcdm_add_i = 32'h1000_0010;
    repeat (2) begin
      settle();
      chk("t3_full_gnt", tcdm_gnt_o, 0);
      chk("t3_full_ar", ar_valid_o, 0);
      tick();
    end
    r_valid_i = 1; r_data_i = 32'h100;
    settle();
    chk("t3_full_ar_pop", ar_valid_o, 0);
    chk("t3_r_ready", r_ready_o, 1);
    tick();
    r_data_i = 32'h101;
    settle();
    chk("t3_ar_after_pop", ar_valid_o, 1);
    chk("t3_gnt_after_pop", tcdm_gnt_o, 1);
    chk("t3_rdata0", tcdm_r_rdata_o, 32'h100);
    tick();
    tcdm_req_i = 0;
    for (int k = 2; k <= 4; k++) begin
      r_data_i = 32'h100 + 32'(k);
      settle();
      chk("t3_rvalid", tcdm_r_valid_o, 1);
      chk("t3_rdata", tcdm_r_rdata_o, 32'h100 + 32'(k - 1));
      tick();
    end
    r_valid_i = 0;
    settle();
    chk("t3_rdata_last", tcdm_r_rdata_o, 32'h104);
    tick();
    settle();
    chk("t3_drained", r_ready_o, 0);

    // Write then read; R offered before B must wait.
    aw_ready_i = 1; w_ready_i = 1; ar_ready_i = 1;
    tcdm_req_i = 1; tcdm_wen_i = 0; tcdm_add_i = 32'h2000_0000;
    tcdm_wdata_i = 32'hCAFE_0001; tcdm_be_i = 4'hF;
    settle();
    chk("t4_wgnt", tcdm_gnt_o, 1);
    tick();
    tcdm_wen_i = 1; tcdm_add_i = 32'h2000_0004;
    settle();
    chk("t4_rgnt", tcdm_gnt_o, 1);
    tick();
    tcdm_req_i = 0;
    r_valid_i = 1; r_data_i = 32'h5555_AAAA;
    settle();
    chk("t4_r_blocked", r_ready_o, 0);
    chk("t4_b_ready", b_ready_o, 1);
    tick();
    b_valid_i = 1; b_resp_i = 0;
    settle();
    chk("t4_r_blocked2", r_ready_o, 0);
    tick();
    b_valid_i = 0;
    settle();
    chk("t4_first_rsp", tcdm_r_valid_o, 1);
    chk("t4_first_is_write", tcdm_r_rdata_o, 0);
    chk("t4_r_ready", r_ready_o, 1);
    tick();
    r_valid_i = 0;
    settle();
    chk("t4_second_rsp", tcdm_r_valid_o, 1);
    chk("t4_second_data", tcdm_r_rdata_o, 32'h5555_AAAA);
    tick();

    // Error responses: DECERR on B, SLVERR on R.
    tcdm_req_i = 1; tcdm_wen_i = 0; tcdm_add_i = 32'h2000_0008;
    settle();
    chk("t5_wgnt", tcdm_gnt_o, 1);
    tick();
    tcdm_req_i = 0;
    b_valid_i = 1; b_resp_i = 2'b11;
    tick();
    b_valid_i = 0; b_resp_i = 0;
    settle();
    chk("t5_b_rvalid", tcdm_r_valid_o, 1);
    chk("t5_b_opc", tcdm_r_opc_o, ERR_EN);
    tick();
    tcdm_req_i = 1; tcdm_wen_i = 1;
    tick();
    tcdm_req_i = 0;
    r_valid_i = 1; r_resp_i = 2'b10; r_data_i = 32'h0BAD_0BAD;
    tick();
    r_valid_i = 0; r_resp_i = 0;
    settle();
    chk("t5_r_opc", tcdm_r_opc_o, ERR_EN);
    chk("t5_r_data", tcdm_r_rdata_o, 32'h0BAD_0BAD);
    tick();

    // Reset with three reads outstanding.
    tcdm_req_i = 1; tcdm_wen_i = 1; ar_ready_i = 1;
    repeat (3) tick();
    tcdm_req_i = 0; rst_i = 1;
    tick();
    rst_i = 0;
    settle();
    chk_zero("t6");
    tcdm_req_i = 1; tcdm_add_i = 32'h1A10_0100;
    settle();
    chk("t6_gnt", tcdm_gnt_o, 1);
    tick();
    tcdm_req_i = 0;
    r_valid_i = 1; r_data_i = 32'h0000_0077;
    settle();
    chk("t6_r_ready", r_ready_o, 1);
    tick();
    r_valid_i = 0;
    settle();
    chk("t6_rvalid", tcdm_r_valid_o, 1);
    chk("t6_rdata", tcdm_r_rdata_o, 32'h77);
    tick();
    settle();
    chk("t6_idle", r_ready_o | b_ready_o, 0);

    // Randomized traffic against the transaction-level model.
    idle();
    m_busy = 0; p_ar_wait = 0; p_aw_wait = 0; p_w_wait = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      drain = (cyc >= 3000);
      if (drain && !m_busy && exp_q.size() == 0) break;
      if (!m_busy && !drain && $urandom_range(0, 3) != 0) begin
        m_busy  = 1;
        m_wen   = $urandom_range(0, 1);
        m_add   = 32'h3000_0000 + 32'(4 * $urandom_range(0, 15));
        m_wdata = $urandom;
        m_be    = 4'($urandom_range(1, 15));
      end
      tcdm_req_i = m_busy; tcdm_wen_i = m_wen; tcdm_add_i = m_add;
      tcdm_wdata_i = m_wdata; tcdm_be_i = m_be;
      aw_ready_i = drain || ($urandom_range(0, 1) == 1);
      w_ready_i  = drain || ($urandom_range(0, 1) == 1);
      ar_ready_i = drain || ($urandom_range(0, 1) == 1);
      if (!r_valid_i && r_q.size() > 0 && (drain || $urandom_range(0, 1) == 1)) begin
        r_valid_i = 1; r_data_i = r_q[0].data; r_resp_i = r_q[0].resp;
      end
      if (!b_valid_i && b_q.size() > 0 && (drain || $urandom_range(0, 1) == 1)) begin
        b_valid_i = 1; b_resp_i = b_q[0].resp;
      end
      settle();

      ar_hs = ar_valid_o && ar_ready_i;
      aw_hs = aw_valid_o && aw_ready_i;
      w_hs  = w_valid_o && w_ready_i;
      r_hs  = r_valid_i && r_ready_o;
      b_hs  = b_valid_i && b_ready_o;
      c_ar_addr = ar_addr_o; c_aw_addr = aw_addr_o; c_w = {w_strb_o, w_data_o};

      if (p_ar_wait) begin
        chk("rnd_ar_hold", ar_valid_o, 1);
        chk("rnd_ar_stable", ar_addr_o, p_ar_addr);
      end
      if (p_aw_wait) begin
        chk("rnd_aw_hold", aw_valid_o, 1);
        chk("rnd_aw_stable", aw_addr_o, p_aw_addr);
      end
      if (p_w_wait) begin
        chk("rnd_w_hold", w_valid_o, 1);
        chk("rnd_w_stable", c_w, p_w);
      end
      if (ord_q.size() == MAX_TXNS) chk("rnd_cap", {ar_valid_o, aw_valid_o, w_valid_o}, 0);
      chk("rnd_r_ready", r_ready_o, (ord_q.size() > 0 && ord_q[0]) ? 1 : 0);
      chk("rnd_b_ready", b_ready_o, (ord_q.size() > 0 && !ord_q[0]) ? 1 : 0);

      if (tcdm_r_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious_rvalid", tcdm_r_valid_o, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_rdata", tcdm_r_rdata_o, e.data);
          chk("rnd_opc", tcdm_r_opc_o, e.opc);
        end
      end

      if (tcdm_gnt_o) begin
        chk("rnd_gnt_req", m_busy, 1);
        old = ref_mem.exists(m_add) ? ref_mem[m_add] : init_word(m_add);
        e.opc = ERR_EN && err_word(m_add);
        if (m_wen) begin
          e.data = old;
        end else begin
          e.data = 0;
          ref_mem[m_add] = merge(old, m_wdata, m_be);
        end
        exp_q.push_back(e);
        ord_q.push_back(m_wen);
        m_busy = 0;
      end

      p_ar_wait = ar_valid_o && !ar_ready_i; p_ar_addr = c_ar_addr;
      p_aw_wait = aw_valid_o && !aw_ready_i; p_aw_addr = c_aw_addr;
      p_w_wait  = w_valid_o && !w_ready_i;   p_w = c_w;
      tick();

      // AXI slave reacts to the handshakes of the cycle just finished.
      if (aw_hs) aw_q.push_back(c_aw_addr);
      if (w_hs)  w_q.push_back(c_w);
      if (aw_q.size() > 0 && w_q.size() > 0) begin
        wa = aw_q.pop_front();
        wd = w_q.pop_front();
        old = smem.exists(wa) ? smem[wa] : init_word(wa);
        smem[wa] = merge(old, wd[31:0], wd[35:32]);
        bt.data = 0; bt.resp = err_word(wa) ? 2'b11 : 2'b00;
        b_q.push_back(bt);
      end
      if (ar_hs) begin
        bt.data = smem.exists(c_ar_addr) ? smem[c_ar_addr] : init_word(c_ar_addr);
        bt.resp = err_word(c_ar_addr) ? 2'b10 : 2'b00;
        r_q.push_back(bt);
      end
      if (r_hs) begin
        void'(r_q.pop_front());
        void'(ord_q.pop_front());
        r_valid_i = 0;
      end
      if (b_hs) begin
        void'(b_q.pop_front());
        void'(ord_q.pop_front());
        b_valid_i = 0;
      end
    end
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_no_req_left", m_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
